// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load, wrap/saturate, tc and sticky ovf
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             r,
  input  logic             EC,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_next;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  // Prescaler phase survives EC=0; only a load realigns it.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_pre <= '0;
    end else if (ld) begin
      r_pre <= '0;
    end else if (EC) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
    end
  end

  assign w_step = (r_pre == PRE_LAST);
`else
  assign w_step = 1'b1;
`endif

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == '0);

  assign tc = EC & ~ld & w_step & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

  always_comb begin
    w_q_next = r_q;
    if (ld) begin
      w_q_next = (D > MAX) ? MAX : D;
    end else if (EC && w_step) begin
      if (up_dn) begin
        if (!w_at_max)          w_q_next = r_q + WIDTH'(1);
        else if (SATURATE == 0) w_q_next = '0;
      end else begin
        if (!w_at_zero)         w_q_next = r_q - WIDTH'(1);
        else if (SATURATE == 0) w_q_next = MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q <= w_q_next;
      // A boundary crossing on the same edge as a clear must not be lost.
      if (tc)           r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - directed self-checking bench for updown_counter_param
// Wrap/saturate tests by default; prescaler test when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       r;
  logic       ec, up_dn, ld, clr_ovf;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, ovf;

  logic       s_ec, s_up_dn, s_ld, s_clr_ovf;
  logic [3:0] s_d;
  logic [3:0] s_q;
  logic       s_tc, s_ovf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clk(clk), .r(r), .EC(ec), .up_dn(up_dn), .ld(ld), .D(d),
    .clr_ovf(clr_ovf), .Q(q), .tc(tc), .ovf(ovf)
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .r(r), .EC(s_ec), .up_dn(s_up_dn), .ld(s_ld), .D(s_d),
    .clr_ovf(s_clr_ovf), .Q(s_q), .tc(s_tc), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r = 1'b0; ec = 0; up_dn = 1; ld = 0; clr_ovf = 0; d = 4'd0;
    s_ec = 0; s_up_dn = 1; s_ld = 0; s_clr_ovf = 0; s_d = 4'd0;
    #12;
    chk("reset_q", 32'(q), 0);
    chk("reset_ovf", 32'(ovf), 0);
    chk("reset_tc", 32'(tc), 0);
    tick();
    r = 1'b1;
    tick();

`ifndef COUNTER_PRESCALE_EN
    begin
      logic [3:0] exp_up [12];
      logic       exp_tc [12];
      exp_up = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      exp_tc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      ec = 1; up_dn = 1;
      for (int i = 0; i < 12; i++) begin
        #1;
        chk($sformatf("up_tc[%0d]", i), 32'(tc), 32'(exp_tc[i]));
        tick();
        chk($sformatf("up_q[%0d]", i), 32'(q), 32'(exp_up[i]));
        chk($sformatf("up_ovf[%0d]", i), 32'(ovf), (i >= 9) ? 32'd1 : 32'd0);
      end
    end

    // Load 7 (ovf kept), then async reset pulse between edges.
    ec = 0; ld = 1; d = 4'd7;
    tick();
    ld = 0;
    chk("load7_q", 32'(q), 7);
    chk("load_keeps_ovf", 32'(ovf), 1);
    #2 r = 1'b0;
    #1;
    chk("async_q", 32'(q), 0);
    chk("async_ovf", 32'(ovf), 0);
    #4 r = 1'b1;
    ec = 1; up_dn = 1;
    tick();
    chk("resume_q", 32'(q), 1);

    // Down wrap from 1.
    up_dn = 0;
    tick();
    chk("dn_q0", 32'(q), 0);
    chk("dn_tc_at0", 32'(tc), 1);
    tick();
    chk("dn_q1", 32'(q), 9);
    chk("dn_ovf", 32'(ovf), 1);
    tick();
    chk("dn_q2", 32'(q), 8);
    ec = 0; clr_ovf = 1;
    tick();
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_hold_q", 32'(q), 8);
    clr_ovf = 0; ld = 1; d = 4'd0;
    tick();
    ld = 0; ec = 1; up_dn = 0; clr_ovf = 1;
    #1;
    chk("clr_vs_tc_tc", 32'(tc), 1);
    tick();
    clr_ovf = 0;
    chk("clr_vs_tc_ovf", 32'(ovf), 1);
    chk("clr_vs_tc_q", 32'(q), 9);

    // Load has priority over count; tc masked by ld.
    up_dn = 1; ec = 1; ld = 1; d = 4'd6;
    #1;
    chk("ld_masks_tc", 32'(tc), 0);
    tick();
    chk("ld_prio_q", 32'(q), 6);
    d = 4'd13;
    tick();
    chk("ld_clamp_q", 32'(q), 9);
    ld = 0; ec = 0;

    // Saturating instance.
    s_ld = 1; s_d = 4'd8;
    tick();
    s_ld = 0; s_ec = 1; s_up_dn = 1;
    tick(); chk("sat_up0", 32'(s_q), 9);
    tick(); chk("sat_up1", 32'(s_q), 9);
    tick(); chk("sat_up2", 32'(s_q), 9);
    chk("sat_ovf", 32'(s_ovf), 1);
    s_ec = 0; s_ld = 1; s_d = 4'd1;
    tick();
    s_ld = 0; s_ec = 1; s_up_dn = 0;
    tick(); chk("sat_dn0", 32'(s_q), 0);
    tick(); chk("sat_dn1", 32'(s_q), 0);
    tick(); chk("sat_dn2", 32'(s_q), 0);
    s_ec = 0;
`else
    begin
      logic [3:0] exp_pre [8];
      exp_pre = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
      ec = 1; up_dn = 1;
      for (int i = 0; i < 8; i++) begin
        tick();
        chk($sformatf("pre_q[%0d]", i), 32'(q), 32'(exp_pre[i]));
      end
    end
    tick();
    tick();
    chk("pre_mid_q", 32'(q), 2);
    ec = 0;
    tick(); tick(); tick();
    chk("pre_frozen_q", 32'(q), 2);
    ec = 1;
    tick();
    chk("pre_phase3_q", 32'(q), 2);
    tick();
    chk("pre_adv_q", 32'(q), 3);
    ec = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
